cw_capture_ctrl: RTL and testbench

- Capture sequencer for the on-chip watcher trace RAM.
- Arms on request and qualifies a mask/value trigger on the probe vector (non-bus plus bus nodes).
- Drives wt_ce/wt_en/wt_addr as a circular pre-trigger buffer followed by a post-trigger count.
- Shares the RAM port with a readback requester when idle or done, and reports trigger/start addresses for trace reconstruction.

---
 rtl/cw_pkg.sv | 17 +
 rtl/cw_trig_match.sv | 29 ++
 rtl/cw_capture_ctrl.sv | 115 +++++++++++
 tb/tb_cw_capture_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cw_pkg.sv
// Shared types and helpers for the watcher capture sequencer.
package cw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int WT_ADDR_W = 16;

    function automatic int clip(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/cw_trig_match.sv
// Mask/value trigger compare with optional rising-edge qualification.
module cw_trig_match #(
    parameter int PROBE_W = 17
) (
    input  logic               trig_clk,
    input  logic               jrstn,
    input  logic               clr,
    input  logic [PROBE_W-1:0] probe,
    input  logic [PROBE_W-1:0] trig_mask,
    input  logic [PROBE_W-1:0] trig_value,
    input  logic               trig_edge,
    output logic               hit
);

    logic match;
    logic match_q;

    assign match = ((probe ^ trig_value) & trig_mask) == '0;

    // Cleared on arm so a match already present at arm counts as an edge.
    always_ff @(posedge trig_clk or negedge jrstn) begin
        if (!jrstn)   match_q <= 1'b0;
        else if (clr) match_q <= 1'b0;
        else          match_q <= match;
    end

    assign hit = trig_edge ? (match & ~match_q) : match;

endmodule

// File: rtl/cw_capture_ctrl.sv
// Trace RAM capture sequencer: circular pre-trigger fill, post-trigger count, idle readback.
module cw_capture_ctrl
    import cw_pkg::*;
#(
    parameter int PROBE_W = 17,
    parameter int ADDR_W  = 10
) (
    input  logic                 trig_clk,
    input  logic                 jrstn,
    input  logic                 arm,
    input  logic                 abort,
    input  logic [PROBE_W-1:0]   probe,
    input  logic [PROBE_W-1:0]   trig_mask,
    input  logic [PROBE_W-1:0]   trig_value,
    input  logic                 trig_edge,
    input  logic [ADDR_W-1:0]    pre_len,
    input  logic [ADDR_W-1:0]    post_len,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic                 wt_ce,
    output logic                 wt_en,
    output logic [WT_ADDR_W-1:0] wt_addr,
    output logic                 busy,
    output logic                 triggered,
    output logic                 done,
    output logic [ADDR_W-1:0]    trig_addr,
    output logic [ADDR_W-1:0]    start_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr, fill_cnt, post_cnt;
    logic [ADDR_W-1:0] pre_eff, post_eff;
    logic [ADDR_W-1:0] pre_next, post_next;
    logic              writing, arm_go, hit, fire;

    assign writing = (state == ARMED) || (state == POST);
    assign arm_go  = arm && !abort && !writing;
    assign fire    = (state == ARMED) && (fill_cnt == pre_eff) && hit;

    // Window must fit the RAM: pre + trigger + post <= DEPTH.
    assign pre_next  = ADDR_W'(clip(int'(pre_len), DEPTH - 1));
    assign post_next = ADDR_W'(clip(int'(post_len), DEPTH - 1 - int'(pre_next)));

    cw_trig_match #(.PROBE_W(PROBE_W)) u_match (
        .trig_clk   (trig_clk),
        .jrstn      (jrstn),
        .clr        (arm_go),
        .probe      (probe),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .trig_edge  (trig_edge),
        .hit        (hit)
    );

    always_ff @(posedge trig_clk or negedge jrstn) begin
        if (!jrstn) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            fill_cnt   <= '0;
            post_cnt   <= '0;
            pre_eff    <= '0;
            post_eff   <= '0;
            triggered  <= 1'b0;
            trig_addr  <= '0;
            start_addr <= '0;
        end else if (arm_go) begin
            state      <= ARMED;
            wr_ptr     <= '0;
            fill_cnt   <= '0;
            post_cnt   <= '0;
            pre_eff    <= pre_next;
            post_eff   <= post_next;
            triggered  <= 1'b0;
            trig_addr  <= '0;
            start_addr <= '0;
        end else if (abort && writing) begin
            state <= IDLE;
        end else if (state == ARMED) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (fill_cnt != pre_eff) fill_cnt <= fill_cnt + ADDR_W'(1);
            if (fire) begin
                triggered  <= 1'b1;
                trig_addr  <= wr_ptr;
                start_addr <= wr_ptr - pre_eff;
                post_cnt   <= post_eff;
                state      <= (post_eff == '0) ? DONE : POST;
            end
        end else if (state == POST) begin
            wr_ptr   <= wr_ptr + ADDR_W'(1);
            post_cnt <= post_cnt - ADDR_W'(1);
            if (post_cnt == ADDR_W'(1)) state <= DONE;
        end
    end

    // RAM port decode uses only registered state plus the readback request.
    always_comb begin
        wt_ce   = 1'b0;
        wt_en   = 1'b0;
        wt_addr = '0;
        if (writing) begin
            wt_ce   = 1'b1;
            wt_en   = 1'b1;
            wt_addr = WT_ADDR_W'(wr_ptr);
        end else if (rd_en) begin
            wt_ce   = 1'b1;
            wt_addr = WT_ADDR_W'(rd_addr);
        end
    end

    assign busy = writing;
    assign done = (state == DONE);

endmodule

// File: tb/tb_cw_capture_ctrl.sv
// Scoreboard bench: expected write addresses queued per capture, popped as the RAM is written.
module tb_cw_capture_ctrl;

    localparam int PW = 17;
    localparam int AW = 4;

    logic          trig_clk = 1'b0;
    logic          jrstn    = 1'b0;
    logic          arm      = 1'b0;
    logic          abort    = 1'b0;
    logic          trig_edge = 1'b0;
    logic          rd_en    = 1'b0;
    logic [PW-1:0] probe      = '0;
    logic [PW-1:0] trig_mask  = '0;
    logic [PW-1:0] trig_value = '0;
    logic [AW-1:0] pre_len  = '0;
    logic [AW-1:0] post_len = '0;
    logic [AW-1:0] rd_addr  = '0;

    logic          wt_ce, wt_en, busy, triggered, done;
    logic [15:0]   wt_addr;
    logic [AW-1:0] trig_addr, start_addr;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    cw_capture_ctrl #(.PROBE_W(PW), .ADDR_W(AW)) dut (
        .trig_clk   (trig_clk),
        .jrstn      (jrstn),
        .arm        (arm),
        .abort      (abort),
        .probe      (probe),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .trig_edge  (trig_edge),
        .pre_len    (pre_len),
        .post_len   (post_len),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .wt_ce      (wt_ce),
        .wt_en      (wt_en),
        .wt_addr    (wt_addr),
        .busy       (busy),
        .triggered  (triggered),
        .done       (done),
        .trig_addr  (trig_addr),
        .start_addr (start_addr)
    );

    always #5 trig_clk = ~trig_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Every RAM write must match the next queued address.
    always @(negedge trig_clk) begin
        if (jrstn && wt_ce && wt_en) begin
            if (exp_q.size() == 0) chk("wr_unexp", 32'(wt_en), 32'd0);
            else                   chk("wr_addr", 32'(wt_addr), 32'(exp_q.pop_front()));
        end
    end

    task automatic cyc();
        @(posedge trig_clk);
        #1;
    endtask

    task automatic push_seq(input int first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(16'((first + i) % 16));
    endtask

    task automatic arm_cap(input int pre, input int post, input bit edge_md);
        arm        = 1'b1;
        pre_len    = pre[AW-1:0];
        post_len   = post[AW-1:0];
        trig_mask  = PW'(1);
        trig_value = PW'(1);
        trig_edge  = edge_md;
        cyc();
        arm = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_ce", 32'(wt_ce), 0);
        chk("rst_en", 32'(wt_en), 0);
        chk("rst_addr", 32'(wt_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_trig", 32'(triggered), 0);
        #12 jrstn = 1'b1;
        cyc();

        // Basic capture: trigger on the 10th armed cycle.
        probe = '0;
        arm_cap(3, 4, 1'b0);
        push_seq(0, 14);
        for (int k = 0; k < 14; k++) begin
            probe = PW'(k == 9);
            cyc();
        end
        probe = '0;
        chk("t1_done", 32'(done), 1);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_trig", 32'(triggered), 1);
        chk("t1_taddr", 32'(trig_addr), 9);
        chk("t1_saddr", 32'(start_addr), 6);
        cyc(); cyc();
        chk("t1_en_after", 32'(wt_en), 0);
        chk("t1_q", exp_q.size(), 0);

        // Level mode, match held from arm: first qualified write is address 3.
        arm_cap(3, 1, 1'b0);
        push_seq(0, 5);
        for (int k = 0; k < 5; k++) begin
            probe = PW'(1);
            cyc();
        end
        chk("t2a_done", 32'(done), 1);
        chk("t2a_taddr", 32'(trig_addr), 3);
        chk("t2a_saddr", 32'(start_addr), 0);
        chk("t2a_q", exp_q.size(), 0);

        // Edge mode with probe held high never qualifies; abort to leave.
        arm_cap(3, 1, 1'b1);
        push_seq(0, 13);
        for (int k = 0; k < 12; k++) begin
            probe = PW'(1);
            cyc();
        end
        chk("t2b_busy", 32'(busy), 1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("t2b_trig", 32'(triggered), 0);
        chk("t2b_busy_ab", 32'(busy), 0);
        chk("t2b_done", 32'(done), 0);
        chk("t2b_q", exp_q.size(), 0);

        // Edge mode: low at 6, high at 7 -> trigger at 7.
        arm_cap(3, 1, 1'b1);
        push_seq(0, 9);
        for (int k = 0; k < 9; k++) begin
            probe = PW'(k != 6);
            cyc();
        end
        chk("t2c_done", 32'(done), 1);
        chk("t2c_taddr", 32'(trig_addr), 7);
        chk("t2c_saddr", 32'(start_addr), 4);
        chk("t2c_q", exp_q.size(), 0);

        // Wrap: trigger on the 20th armed cycle; readback request ignored while armed.
        rd_en   = 1'b1;
        rd_addr = 4'd5;
        probe   = '0;
        arm_cap(5, 2, 1'b0);
        push_seq(0, 22);
        for (int k = 0; k < 22; k++) begin
            probe = PW'(k == 19);
            cyc();
        end
        chk("t3_done", 32'(done), 1);
        chk("t3_taddr", 32'(trig_addr), 3);
        chk("t3_saddr", 32'(start_addr), 14);
        chk("t3_q", exp_q.size(), 0);
        chk("t3_rd_ce", 32'(wt_ce), 1);
        chk("t3_rd_en", 32'(wt_en), 0);
        rd_en = 1'b0;

        // Maximum pre (port limit 15) leaves post_eff = 0: trigger write only.
        arm_cap(15, 15, 1'b0);
        push_seq(0, 16);
        for (int k = 0; k < 16; k++) begin
            probe = PW'(1);
            cyc();
        end
        chk("t4_done", 32'(done), 1);
        chk("t4_taddr", 32'(trig_addr), 15);
        chk("t4_saddr", 32'(start_addr), 0);
        cyc(); cyc();
        chk("t4_q", exp_q.size(), 0);

        // Readback while done.
        rd_en   = 1'b1;
        rd_addr = 4'd5;
        #1;
        chk("rd_ce", 32'(wt_ce), 1);
        chk("rd_en", 32'(wt_en), 0);
        chk("rd_addr", 32'(wt_addr), 5);
        rd_en = 1'b0;
        #1;
        chk("rd_off_ce", 32'(wt_ce), 0);

        // Abort during POST keeps triggered.
        cyc();
        arm_cap(2, 5, 1'b0);
        push_seq(0, 5);
        for (int k = 0; k < 4; k++) begin
            probe = PW'(1);
            cyc();
        end
        chk("t5_post_busy", 32'(busy), 1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(done), 0);
        chk("t5_trig", 32'(triggered), 1);
        chk("t5_en", 32'(wt_en), 0);
        chk("t5_q", exp_q.size(), 0);

        // Arm and abort together in IDLE: abort wins.
        arm   = 1'b1;
        abort = 1'b1;
        cyc();
        arm   = 1'b0;
        abort = 1'b0;
        chk("t5b_busy", 32'(busy), 0);
        chk("t5b_done", 32'(done), 0);
        chk("t5b_en", 32'(wt_en), 0);
        cyc();

        // Reset mid-ARMED clears everything immediately.
        probe = '0;
        arm_cap(3, 4, 1'b0);
        push_seq(0, 3);
        for (int k = 0; k < 3; k++) cyc();
        jrstn = 1'b0;
        #1;
        chk("t7_ce", 32'(wt_ce), 0);
        chk("t7_en", 32'(wt_en), 0);
        chk("t7_addr", 32'(wt_addr), 0);
        chk("t7_busy", 32'(busy), 0);
        chk("t7_done", 32'(done), 0);
        chk("t7_taddr", 32'(trig_addr), 0);
        chk("t7_saddr", 32'(start_addr), 0);
        #2 jrstn = 1'b1;
        cyc(); cyc();
        chk("t7_q", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
